// File: rtl/mem_stream_loader.sv
// mem_stream_loader: packs a byte stream MSB-first into words, fills RAM 0..DEPTH-1, registered read port
module mem_stream_loader #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);
  localparam int BYTES = WIDTH / 8;
  localparam int BC_W  = BYTES > 1 ? $clog2(BYTES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [BC_W-1:0]   r_bc;
  logic [WIDTH-1:0]  r_asm;
  logic [ADDR_W:0]   r_cnt;
  logic [WIDTH-1:0]  r_rd;
  logic              w_accept, w_last_byte, w_last_word, w_wr;
  logic [WIDTH-1:0]  w_word;
  assign w_accept    = (r_state == LOAD) && !abort && in_valid;
  assign w_last_byte = r_bc == BC_W'(BYTES - 1);
  assign w_last_word = r_addr == ADDR_W'(DEPTH - 1);
  assign w_wr        = w_accept && w_last_byte;
  assign w_word      = (r_asm << 8) | WIDTH'(in_data);
  assign in_ready    = (r_state == LOAD) && !abort;
  assign busy        = r_state == LOAD;
  assign done        = r_state == DONE;
  assign rd_data     = r_rd;
  assign wr_count    = r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = abort ? IDLE : (w_wr && w_last_word) ? DONE : LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_bc    <= '0;
      r_asm   <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      r_rd    <= r_mem[rd_addr];
      if (r_state == IDLE && start) begin
        r_addr <= '0;
        r_bc   <= '0;
        r_cnt  <= '0;
      end
      if (w_accept) begin
        r_asm <= w_word;
        r_bc  <= w_last_byte ? '0 : r_bc + BC_W'(1);
        if (w_last_byte) begin
          r_addr <= w_last_word ? '0 : r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt + (ADDR_W + 1)'(1);
        end
      end
    end
  end
  // RAM contents survive reset; the write is merely blocked on a reset edge
  always_ff @(posedge clk) begin
    if (rst_n && w_wr) r_mem[r_addr] <= w_word;
  end
endmodule

// File: tb/tb_mem_stream_loader.sv
// tb_mem_stream_loader: scoreboard bench for mem_stream_loader (WIDTH=16, DEPTH=16)
module tb_mem_stream_loader;
  logic        clk = 0;
  logic        rst_n, start, abort, in_valid, in_ready, busy, done;
  logic [7:0]  in_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [4:0]  wr_count;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_mem [16];
  logic [15:0] q [$];
  logic [15:0] m_asm;
  int          m_addr, m_cnt, m_half;

  mem_stream_loader #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    start = 1;
    step();
    start = 0;
    m_addr = 0; m_cnt = 0; m_half = 0;
    chk("start_busy", busy, 1);
    chk("start_cnt", wr_count, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      in_valid = 0;
      step();
      chk("gap_busy", busy, 1);
    end
    in_data = b;
    in_valid = 1;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    m_asm = {m_asm[7:0], b};
    if (m_half == 1) begin
      exp_mem[m_addr] = m_asm;
      m_addr = (m_addr + 1) % 16;
      m_cnt++;
    end
    m_half = 1 - m_half;
    chk("wr_count", wr_count, m_cnt);
    if (m_cnt == 16 && m_half == 0) begin
      chk("done_hi", done, 1);
      chk("done_busy", busy, 0);
      chk("done_ready", in_ready, 0);
      step();
      chk("done_pulse", done, 0);
      chk("done_count", wr_count, 16);
    end else chk("done_lo", done, 0);
  endtask

  task automatic load_img(input logic [7:0] base, input bit gap);
    begin_load();
    for (int i = 0; i < 32; i++) send_byte(base + 8'(i), gap);
  endtask

  task automatic readback_all();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      q.push_back(exp_mem[a]);
      step();
      chk($sformatf("rd%0d", a), rd_data, q.pop_front());
    end
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; in_valid = 0; in_data = 0; rd_addr = 0;
    m_asm = 0; m_addr = 0; m_cnt = 0; m_half = 0;
    step();
    step();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_cnt", wr_count, 0);
    rst_n = 1;
    step();

    load_img(8'h00, 0);
    readback_all();

    load_img(8'h00, 1);
    readback_all();

    begin_load();
    send_byte(8'hA0, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    abort = 1; in_valid = 1; in_data = 8'hEE;
    #1;
    chk("abort_ready", in_ready, 0);
    step();
    abort = 0; in_valid = 0; m_half = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", wr_count, 1);
    step();
    chk("abort_done2", done, 0);
    readback_all();

    abort = 1;
    step();
    abort = 0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_ready", in_ready, 0);
    begin_load();
    for (int i = 0; i < 32; i++) begin
      start = (i == 5);
      send_byte(8'h60 + 8'(i), 0);
      start = 0;
    end
    readback_all();

    begin_load();
    for (int i = 0; i < 9; i++) send_byte(8'h80 + 8'(i), 0);
    rst_n = 0;
    step();
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", rd_data, 0);
    chk("mid_rst_cnt", wr_count, 0);
    rst_n = 1;
    m_half = 0;
    step();
    readback_all();
    load_img(8'h40, 0);
    readback_all();

    load_img(8'h00, 0);
    rd_addr = 2;
    begin_load();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 0);
    q.push_back(exp_mem[2]);
    send_byte(8'hC5, 0);
    chk("rbw_old", rd_data, q.pop_front());
    q.push_back(exp_mem[2]);
    step();
    chk("rbw_new", rd_data, q.pop_front());
    for (int i = 6; i < 32; i++) send_byte(8'hC0 + 8'(i), 0);
    readback_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Writer-side counterpart to the team's file-initialised ROMs: fills a synchronous RAM at run time from a byte stream instead of a hex file.
- Accepts bytes over a valid/ready handshake and packs them MSB-first into WIDTH-bit words.
- Writes the words to consecutive addresses 0..DEPTH-1 and pulses done when the image is complete.
- An independent registered read port serves the datapath that previously read the ROM.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8 (BYTES = WIDTH/8).
- DEPTH, 16, number of words; must be at least 2.
- ADDR_W, 4, address width; ceil(log2(DEPTH)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin a load; sampled in IDLE only.
- abort  input  1  cancel an in-progress load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  WIDTH  registered read data.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when the final word is written.
- wr_count  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready=0, busy=0, done=0, rd_data=0, wr_count=0; address and byte counters and the assembly register cleared. RAM contents are not reset.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD next cycle; clears address, byte counter and wr_count.
  - abort is ignored.
- LOAD:
  - busy=1; in_ready=1 combinationally, unless abort=1 (then in_ready=0).
  - A byte is accepted when in_valid && in_ready.
  - Each accepted byte shifts in: asm <= {asm[WIDTH-9:0], in_data}. The first byte of a word ends up in the MSBs.
  - The byte counter counts 0..BYTES-1.
  - On the accept that completes a word (byte counter = BYTES-1):
    - mem[addr] <= {asm[WIDTH-9:0], in_data} in that same edge;
    - addr increments; wr_count increments; byte counter returns to 0.
  - If that write is to addr = DEPTH-1 -> DONE. Address wraps to 0; no further writes.
  - in_valid=0 stalls without side effects; gaps between bytes are allowed.
  - start in LOAD is ignored.
- abort=1 in LOAD:
  - -> IDLE next cycle; no byte is accepted that cycle.
  - A partially assembled word is discarded.
  - Words already written remain; wr_count holds the count of complete words.
  - No done pulse.
- DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0; -> IDLE unconditionally.
  - done is asserted in the cycle after the edge on which the last byte was accepted.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in any state; latency 1 cycle.
  - Same-cycle write and read of the same address: rd_data returns the old contents (read-before-write).
  - rd_addr >= DEPTH is out of range and rd_data is undefined; the bench must not check it.
- Reset mid-load:
  - Behaves as reset: state IDLE, counters cleared, partial word lost.
  - Already-written RAM words are kept.
- Throughput: one byte per cycle sustained. A full load of DEPTH*BYTES bytes takes DEPTH*BYTES accepting cycles, plus 1 cycle for start and 1 cycle for DONE.

Test Plan (WIDTH=16, DEPTH=16):
- Full load:
  - Stimulus: rst_n low 2 cycles, start pulse, then 32 back-to-back bytes 0x00..0x1F.
  - Response: done pulses once, one cycle after byte 0x1F is accepted; wr_count=16. Readback: rd_addr=0 gives 0x0001, addr 7 gives 0x0E0F, addr 15 gives 0x1E1F, each one cycle after rd_addr is applied.
- Stalled stream:
  - Stimulus: same 32 bytes with in_valid toggling 1/0 every cycle.
  - Response: identical RAM contents and wr_count=16; done only after the 32nd accept; busy high throughout.
- Abort mid-word:
  - Stimulus: first load 0x00..0x1F to completion; then start and send bytes 0xA0,0xA1,0xA2 followed by abort.
  - Response: state returns to IDLE, no done, wr_count=1, mem[0]=0xA0A1, mem[1] still 0x0203.
- Ignored controls:
  - Stimulus: pulse start during LOAD after 5 bytes; pulse abort while IDLE.
  - Response: load continues unaffected and completes normally; IDLE remains IDLE with in_ready=0.
- Reset mid-load:
  - Stimulus: rst_n=0 for one edge after 9 bytes, then a fresh start and a full load of 0x40..0x5F.
  - Response: outputs reset values after the reset edge; final mem[0]=0x4041, mem[15]=0x5E5F.
- Read during write:
  - Stimulus: with mem[2]=0x0405, hold rd_addr=2 during the reload edge that writes 0xC4C5 to address 2.
  - Response: rd_data=0x0405 after that edge and 0xC4C5 on the following cycle.
